// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MAR/MDR memory access stage sequencing single-word RAM reads/writes
module mem_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              addr_err,
    output logic [31:0]       ram_addr,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_mdatain,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAPT  = 3'd2,
        WR_ISSUE = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t state;

    // Range check must see the MAR value as it will be after this edge.
    logic [DATA_W-1:0] mar_next;
    logic              out_of_range;

    assign mar_next     = mar_in ? bus_in : mar_q;
    assign out_of_range = (mar_next >= DATA_W'(DEPTH));

    assign ram_addr    = {{(32-ADDR_W){1'b0}}, mar_q[ADDR_W-1:0]};
    assign ram_mdatain = mdr_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            mar_q     <= '0;
            mdr_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_err  <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
        end else begin
            done      <= 1'b0;
            addr_err  <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (mar_in) mar_q <= bus_in;
                    if (mdr_in) mdr_q <= bus_in;
                    if (read || write) begin
                        busy <= 1'b1;
                        if (out_of_range) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            addr_err <= 1'b1;
                        end else if (write) begin
                            state     <= WR_ISSUE;
                            ram_write <= 1'b1;
                        end else begin
                            state    <= RD_ISSUE;
                            ram_read <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: state <= RD_CAPT;
                RD_CAPT: begin
                    // RAM read port is registered: data arrives one cycle after the strobe.
                    mdr_q <= ram_q;
                    state <= DONE;
                    done  <= 1'b1;
                end
                WR_ISSUE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [31:0] bus_in;
    logic        mar_in, mdr_in, read, write;
    logic [31:0] mar_q, mdr_q;
    logic        busy, done, addr_err;
    logic [31:0] ram_addr;
    logic        ram_read, ram_write;
    logic [31:0] ram_mdatain, ram_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .read(read), .write(write), .mar_q(mar_q), .mdr_q(mdr_q), .busy(busy),
        .done(done), .addr_err(addr_err), .ram_addr(ram_addr), .ram_read(ram_read),
        .ram_write(ram_write), .ram_mdatain(ram_mdatain), .ram_q(ram_q)
    );

    // Environment RAM with a registered read port.
    logic [31:0] ram_mem [512];
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr[8:0]] <= ram_mdatain;
        if (ram_read)  ram_q <= ram_mem[ram_addr[8:0]];
    end

    // Reference model state.
    logic [31:0] model_mem [512];
    logic [31:0] e_mar, e_mdr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        mar_in = 1'b0; mdr_in = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic do_access(input bit ld_mar, input bit ld_mdr, input logic [31:0] bus,
                             input bit rd, input bit wr, input bit noise);
        bit want, err, ram_ok;
        int exp_lat, got_lat, ndone, nrd, nwr;
        @(negedge clk);
        bus_in = bus; mar_in = ld_mar; mdr_in = ld_mdr; read = rd; write = wr;
        if (ld_mar) e_mar = bus;
        if (ld_mdr) e_mdr = bus;
        want    = rd || wr;
        err     = want && (e_mar >= 32'd512);
        exp_lat = !want ? 0 : err ? 1 : wr ? 2 : 3;
        ram_ok  = want && !err;
        if (ram_ok && wr)      model_mem[e_mar[8:0]] = e_mdr;
        else if (ram_ok && rd) e_mdr = model_mem[e_mar[8:0]];
        @(posedge clk);
        got_lat = 0; ndone = 0; nrd = 0; nwr = 0;
        for (int k = 1; k <= exp_lat + 2; k++) begin
            @(negedge clk);
            if (noise && k <= exp_lat) begin
                bus_in = $urandom; mar_in = 1'($urandom); mdr_in = 1'($urandom);
                read = 1'($urandom); write = 1'($urandom);
            end else begin
                idle_inputs();
            end
            if (k == 1) check("busy_after_accept", busy, want);
            if (ram_read && ram_write) check("strobe_exclusive", 1, 0);
            if (ram_read) begin
                nrd++;
                check("rd_addr", ram_addr, {23'd0, e_mar[8:0]});
            end
            if (ram_write) begin
                nwr++;
                check("wr_addr", ram_addr, {23'd0, e_mar[8:0]});
                check("wr_data", ram_mdatain, e_mdr);
            end
            if (done) begin
                ndone++;
                got_lat = k;
                check("addr_err", addr_err, err);
                check("mdr_at_done", mdr_q, e_mdr);
            end else if (addr_err) begin
                check("addr_err_without_done", addr_err, 0);
            end
        end
        check("done_count", ndone, want ? 1 : 0);
        check("done_latency", got_lat, exp_lat);
        check("ram_read_count", nrd, (ram_ok && !wr) ? 1 : 0);
        check("ram_write_count", nwr, (ram_ok && wr) ? 1 : 0);
        check("busy_end", busy, 0);
        check("mar_q", mar_q, e_mar);
        check("mdr_q", mdr_q, e_mdr);
    endtask

    initial begin
        logic [31:0] addr, v;
        int ndone;
        for (int i = 0; i < 512; i++) begin
            v = $urandom;
            ram_mem[i]   = v;
            model_mem[i] = v;
        end
        clr_n = 1'b0; bus_in = '0; idle_inputs();
        e_mar = '0; e_mdr = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mar", mar_q, 0);
        check("rst_mdr", mdr_q, 0);
        check("rst_strobes", {ram_read, ram_write, addr_err}, 0);
        clr_n = 1'b1;

        // Reset during RD_ISSUE aborts the access.
        @(negedge clk);
        bus_in = 32'h20; mar_in = 1'b1; read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        check("rd_issue_strobe", ram_read, 1);
        clr_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_read", ram_read, 0);
        check("midrst_done", done, 0);
        check("midrst_mar", mar_q, 0);
        check("midrst_mdr", mdr_q, 0);
        @(negedge clk);
        clr_n = 1'b1;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);

        // Directed scenarios.
        do_access(1, 0, 32'h95, 0, 0, 0);
        do_access(0, 1, 32'hDEADBEEF, 0, 1, 0);
        check("ram_95", ram_mem[9'h95], 32'hDEADBEEF);
        do_access(0, 0, 32'h0, 1, 0, 0);
        check("read_back_95", mdr_q, 32'hDEADBEEF);
        do_access(1, 0, 32'h200, 1, 0, 0);
        do_access(1, 0, 32'h10, 0, 0, 0);
        do_access(0, 1, 32'h5, 1, 1, 1);
        check("ram_10", ram_mem[9'h10], 32'h5);
        do_access(1, 0, 32'h1FF, 0, 1, 0);
        check("ram_1ff", ram_mem[9'h1FF], 32'h5);

        // Randomized traffic, biased towards the range boundary.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 5))
                0:       addr = 32'd511;
                1:       addr = 32'd512;
                2:       addr = $urandom;
                default: addr = $urandom_range(0, 511);
            endcase
            if ($urandom_range(0, 1) == 1) do_access(1, 0, addr, 0, 0, 0);
            do_access(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 512; i++)
            if (ram_mem[i] !== model_mem[i]) check("ram_final", ram_mem[i], model_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
